// File: rtl/fft_twiddle_sequencer_if.sv
// Twiddle sequencer bus: start/mode request, ROM address/data, per-stage bank handshake.
// The master modport is the sequencer; the slave modport is the datapath/ROM side.
interface fft_twiddle_sequencer_if #(
  parameter int WIDTH = 16
);
  logic                  start;
  logic                  inverse;
  logic                  stage_ack;
  logic [2:0]            tw_addr;
  logic [WIDTH*16-1:0]   rom_real;
  logic [WIDTH*16-1:0]   rom_imag;
  logic [WIDTH*16-1:0]   tw_real;
  logic [WIDTH*16-1:0]   tw_imag;
  logic [2:0]            stage_idx;
  logic                  stage_valid;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, inverse, stage_ack, rom_real, rom_imag,
    output tw_addr, tw_real, tw_imag, stage_idx, stage_valid, busy, done
  );

  modport slave (
    output start, inverse, stage_ack, rom_real, rom_imag,
    input  tw_addr, tw_real, tw_imag, stage_idx, stage_valid, busy, done
  );
endinterface

// File: rtl/fft_twiddle_sequencer.sv
// Steps through FFT stages, fetching one twiddle bank per stage (1-cycle FETCH) and holding it
// in PRESENT until stage_ack; stage k first valid 2+2k cycles after start, done one cycle after last ack.
module fft_twiddle_sequencer #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 5
) (
  input  logic                    CLK,
  input  logic                    RST,
  fft_twiddle_sequencer_if.master bus
);
  localparam int              BW        = WIDTH * 16;
  localparam logic [2:0]      LAST      = 3'(STAGES - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = ~MOST_NEG;

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

  state_t          state;
  logic            mode;
  logic [2:0]      stage_idx_q;
  logic [BW-1:0]   tw_real_q;
  logic [BW-1:0]   tw_imag_q;
  logic            stage_valid_q;
  logic            busy_q;
  logic            done_q;
  logic [BW-1:0]   imag_conj;

  // Negation of the most-negative code has no representation; clamp it.
  function automatic logic [WIDTH-1:0] sat_neg(input logic [WIDTH-1:0] v);
    if (v == MOST_NEG) return MOST_POS;
    return -v;
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_conj
    assign imag_conj[WIDTH*i +: WIDTH] = sat_neg(bus.rom_imag[WIDTH*i +: WIDTH]);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state         <= IDLE;
      mode          <= 1'b0;
      stage_idx_q   <= 3'd0;
      tw_real_q     <= '0;
      tw_imag_q     <= '0;
      stage_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            stage_idx_q <= 3'd0;
            mode        <= bus.inverse;
            busy_q      <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          tw_real_q     <= bus.rom_real;
          tw_imag_q     <= mode ? imag_conj : bus.rom_imag;
          stage_valid_q <= 1'b1;
          state         <= PRESENT;
        end
        PRESENT: begin
          if (bus.stage_ack) begin
            stage_valid_q <= 1'b0;
            if (stage_idx_q == LAST) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              stage_idx_q <= stage_idx_q + 3'd1;
              state       <= FETCH;
            end
          end
        end
        DONE: begin
          // Park the address at 0 so the ROM sees stage 0 while idle.
          stage_idx_q <= 3'd0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tw_addr     = stage_idx_q;
  assign bus.stage_idx   = stage_idx_q;
  assign bus.tw_real     = tw_real_q;
  assign bus.tw_imag     = tw_imag_q;
  assign bus.stage_valid = stage_valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Directed/randomized bench for fft_twiddle_sequencer with a lane-level conjugation model and
// a per-stage expected timeline (FETCH, PRESENT xN, DONE, IDLE).
module tb_fft_twiddle_sequencer;
  localparam int WIDTH  = 16;
  localparam int STAGES = 5;
  localparam int BW     = WIDTH * 16;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [BW-1:0] rom_r [8];
  logic [BW-1:0] rom_i [8];
  int n_checks = 0;
  int n_fail   = 0;

  fft_twiddle_sequencer_if #(.WIDTH(WIDTH)) bus ();

  fft_twiddle_sequencer #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  assign bus.rom_real = rom_r[bus.tw_addr];
  assign bus.rom_imag = rom_i[bus.tw_addr];

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Conjugate bank: each signed lane negated, clamped to the positive range.
  function automatic logic [BW-1:0] exp_imag(input logic [BW-1:0] raw, input bit inv);
    logic [BW-1:0] r;
    r = raw;
    if (inv) begin
      for (int i = 0; i < 16; i++) begin
        int v;
        int n;
        v = $signed(raw[WIDTH*i +: WIDTH]);
        n = -v;
        if (n > (2**(WIDTH-1)) - 1) n = (2**(WIDTH-1)) - 1;
        r[WIDTH*i +: WIDTH] = n[WIDTH-1:0];
      end
    end
    return r;
  endfunction

  task automatic fill_rom();
    for (int a = 0; a < 8; a++)
      for (int c = 0; c < BW/32; c++) begin
        rom_r[a][32*c +: 32] = $urandom;
        rom_i[a][32*c +: 32] = $urandom;
      end
    rom_i[1][15*WIDTH +: WIDTH] = 16'hFF00;
    rom_i[1][0 +: WIDTH]        = 16'h8000;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},  BW'(bus.busy), '0);
    chk({tag, "_done"},  BW'(bus.done), '0);
    chk({tag, "_valid"}, BW'(bus.stage_valid), '0);
    chk({tag, "_addr"},  BW'(bus.tw_addr), '0);
  endtask

  // Entered and left at a negedge while the DUT is idle.
  task automatic do_transform(input bit inv, input bit tied, input int hold_stage,
                              input int hold_len, input bit noise);
    bus.start     = 1'b1;
    bus.inverse   = inv;
    bus.stage_ack = noise ? 1'($urandom) : 1'b0;
    @(negedge CLK);
    for (int k = 0; k < STAGES; k++) begin
      int waits;
      chk("fetch_valid", BW'(bus.stage_valid), '0);
      chk("fetch_busy",  BW'(bus.busy), BW'(1));
      chk("fetch_done",  BW'(bus.done), '0);
      chk("fetch_addr",  BW'(bus.tw_addr), BW'(k));
      if (noise) begin
        bus.start = 1'($urandom); bus.inverse = 1'($urandom); bus.stage_ack = 1'($urandom);
      end else begin
        bus.start = 1'b0; bus.stage_ack = tied;
      end
      @(negedge CLK);
      waits = (k == hold_stage) ? hold_len : 0;
      for (int w = 0; w <= waits; w++) begin
        chk("pres_valid", BW'(bus.stage_valid), BW'(1));
        chk("pres_idx",   BW'(bus.stage_idx), BW'(k));
        chk("pres_addr",  BW'(bus.tw_addr), BW'(k));
        chk("pres_busy",  BW'(bus.busy), BW'(1));
        chk("pres_done",  BW'(bus.done), '0);
        chk("pres_real",  bus.tw_real, rom_r[k]);
        chk("pres_imag",  bus.tw_imag, exp_imag(rom_i[k], inv));
        if (inv && k == 1 && w == 0) begin
          logic [BW-1:0] t;
          t = bus.tw_imag;
          chk("conj_lane15", BW'(t[15*WIDTH +: WIDTH]), BW'(16'h0100));
          chk("conj_lane0",  BW'(t[0 +: WIDTH]),        BW'(16'h7FFF));
        end
        bus.stage_ack = (w == waits);
        if (noise) begin
          bus.start = 1'($urandom); bus.inverse = 1'($urandom);
        end
        @(negedge CLK);
      end
    end
    chk("done_pulse", BW'(bus.done), BW'(1));
    chk("done_busy",  BW'(bus.busy), BW'(1));
    chk("done_valid", BW'(bus.stage_valid), '0);
    bus.start     = noise;
    bus.stage_ack = noise ? 1'($urandom) : 1'b0;
    @(negedge CLK);
    check_idle("after_done");
    bus.start     = 1'b0;
    bus.stage_ack = noise ? 1'($urandom) : 1'b0;
    @(negedge CLK);
    check_idle("idle_gap");
    bus.stage_ack = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.inverse = 1'b0; bus.stage_ack = 1'b0;
    fill_rom();
    RST = 1'b0;
    bus.start = 1'b1; bus.stage_ack = 1'b1;
    repeat (2) @(negedge CLK);
    check_idle("reset");
    chk("reset_real", bus.tw_real, '0);
    chk("reset_imag", bus.tw_imag, '0);
    chk("reset_idx",  BW'(bus.stage_idx), '0);
    bus.start = 1'b0; bus.stage_ack = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check_idle("post_reset");

    do_transform(1'b0, 1'b1, -1, 0, 1'b0);
    do_transform(1'b1, 1'b1, -1, 0, 1'b0);
    fill_rom();
    do_transform(1'b0, 1'b0, 2, 7, 1'b0);
    do_transform(1'b1, 1'b0, 3, 4, 1'b1);
    do_transform(1'b0, 1'b0, 0, 2, 1'b1);

    // Abort in PRESENT of stage 3 with ack held high.
    bus.start = 1'b1; bus.inverse = 1'b1; bus.stage_ack = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    repeat (7) @(negedge CLK);
    chk("abort_pre_valid", BW'(bus.stage_valid), BW'(1));
    chk("abort_pre_idx",   BW'(bus.stage_idx), BW'(3));
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1; bus.stage_ack = 1'b0;
    check_idle("abort");
    chk("abort_idx",  BW'(bus.stage_idx), '0);
    chk("abort_real", bus.tw_real, '0);
    chk("abort_imag", bus.tw_imag, '0);
    @(negedge CLK);
    check_idle("abort_nodone");
    // Restart after abort must begin at stage 0 in forward mode.
    do_transform(1'b0, 1'b1, -1, 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      fill_rom();
      do_transform(1'($urandom), 1'($urandom), int'($urandom_range(0, STAGES-1)),
                   int'($urandom_range(0, 5)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_twiddle_sequencer.md
FFT_TWIDDLE_SEQUENCER -- requirements
Module: fft_twiddle_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bit width of one twiddle lane; each bank holds 16 lanes.
REQ-002 SHALL have parameter STAGES, default 5: butterfly stages per transform (32-point DIT).
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request to begin a transform; sampled only in IDLE.
REQ-006 SHALL have port inverse  input  1  1 = IFFT (conjugate twiddles); sampled with accepted start.
REQ-007 SHALL have port stage_ack  input  1  datapath has consumed the presented stage.
REQ-008 SHALL have port tw_addr  output  3  stage address to real and imag twiddle ROMs.
REQ-009 SHALL have port rom_real  input  WIDTH*16  combinational real ROM data for tw_addr.
REQ-010 SHALL have port rom_imag  input  WIDTH*16  combinational imag ROM data for tw_addr.
REQ-011 SHALL have port tw_real  output  WIDTH*16  registered real bank for current stage.
REQ-012 SHALL have port tw_imag  output  WIDTH*16  registered imag bank, conjugated when inverse.
REQ-013 SHALL have port stage_idx  output  3  index of stage being fetched/presented.
REQ-014 SHALL have port stage_valid  output  1  tw_real/tw_imag/stage_idx valid for datapath.
REQ-015 SHALL have port busy  output  1  high from accepted start until done cycle inclusive.
REQ-016 SHALL have port done  output  1  one-cycle pulse after final stage acknowledged.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, PRESENT, DONE.
REQ-018 SHALL leave IDLE only on start=1: stage_idx<=0, latch inverse into mode register, go FETCH.
REQ-019 SHALL drive tw_addr = stage_idx combinationally in all states (0 in IDLE).
REQ-020 SHALL spend exactly one cycle in FETCH, capturing rom_real and rom_imag into tw_real/tw_imag on the edge leaving FETCH, then go PRESENT.
REQ-021 SHALL assert stage_valid only in PRESENT and hold banks and stage_idx stable while in PRESENT.
REQ-022 SHALL sample stage_ack only in PRESENT; stage_ack in any other state SHALL be ignored.
REQ-023 On stage_ack in PRESENT with stage_idx < STAGES-1: stage_idx increments by 1, go FETCH.
REQ-024 On stage_ack in PRESENT with stage_idx = STAGES-1: go DONE; done=1 for that single DONE cycle, then IDLE.
REQ-025 Lane i SHALL occupy bits [WIDTH*i +: WIDTH]; lanes are two's complement.
REQ-026 When mode=1, each imag lane SHALL be stored negated (two's complement); most-negative value (0x8000 for WIDTH=16) SHALL saturate to most-positive (0x7FFF).
REQ-027 When mode=0, imag lanes SHALL pass unmodified; real lanes SHALL always pass unmodified.
REQ-028 start while not IDLE (including DONE) SHALL be ignored and SHALL NOT change mode.
REQ-029 busy SHALL be 1 in FETCH, PRESENT, DONE and 0 in IDLE.
REQ-030 Minimum latency with stage_ack held high: start sampled at edge 0, stage_valid first high cycle 2, stage k presented in cycle 2+2k, done high cycle 2*STAGES+1.

Reset
REQ-031 On RST=0 at a clock edge, regardless of state: state IDLE, stage_idx 0, mode 0, tw_real 0, tw_imag 0, stage_valid 0, busy 0, done 0.
REQ-032 Reset mid-transform SHALL abort without done pulse; next transform SHALL restart at stage 0.

Verification
REQ-033 Forward run: start=1, inverse=0, stage_ack tied 1 -> stage_valid high cycles 2,4,6,8,10 with stage_idx 0..4; tw_addr matches stage_idx; done high cycle 11 only; busy high cycles 1-11.
REQ-034 Inverse conjugation: ROM model imag lane 15 at address 1 = 0xFF00, lane 0 = 0x8000; inverse=1 -> in stage 1 tw_imag lane 15 = 0x0100, lane 0 = 0x7FFF; tw_real equals rom_real.
REQ-035 Back-pressure: withhold stage_ack 7 cycles in stage 2 -> stage_valid, stage_idx=2 and banks constant for 7 cycles; advance to FETCH of stage 3 on the edge after ack.
REQ-036 Ignored inputs: start pulses and inverse toggles during busy, stage_ack pulses in IDLE/FETCH -> no state, mode or bank change; exactly one done per accepted start.
REQ-037 Reset mid-operation: RST=0 for one edge while in PRESENT of stage 3 -> all outputs 0 next cycle, no done; subsequent start presents stage 0 at cycle 2.
